// File: rtl/pulse_seq_gen.sv
// pulse_seq_gen: command-driven Iz/Pr pulse timing sequencer; `define PULSE_IDX_EN adds the PULSE_IDX output
module pulse_seq_gen #(
    parameter int TW = 64,
    parameter int IW = 32
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic [TW-1:0] TIME,
    input  logic          DATA_WR,
    input  logic [TW-1:0] TIME_START,
    input  logic [15:0]   N_impulse,
    input  logic [1:0]    TYPE_impulse,
    input  logic [IW-1:0] Interval_Ti,
    input  logic [IW-1:0] Interval_Tp,
    input  logic [IW-1:0] Tblank1,
    input  logic [IW-1:0] Tblank2,
    input  logic          ABORT,
    output logic          En_Iz,
    output logic          En_Pr,
    output logic          DDS_START,
    output logic          BUSY,
    output logic          REQ_COMM,
    output logic          LATE,
    output logic          CMD_REJ
`ifdef PULSE_IDX_EN
    ,
    output logic [15:0]   PULSE_IDX
`endif
);

    // ADV is the one-cycle impulse used when every phase length is zero; as a
    // look-ahead target it also means "no further phase in this impulse"
    typedef enum logic [2:0] {IDLE, ARMED, IZ, BL1, PR, BL2, ADV} state_t;

    state_t        state, nxt, r0, r1, r2, r3, afterPhase;
    logic [TW-1:0] tStart;
    logic [15:0]   nImp, idx, nxtIdx;
    logic [1:0]    typ;
    logic [IW-1:0] ti, tp, tb1, tb2, cnt, nxtCnt;
    logic          load, dds, req, beginImp, endImp;

    assign load = state == IDLE && DATA_WR;

    // first non-empty phase from each point of the Iz/Bl1/Pr/Bl2 order
    assign r3 = tb2 != '0 ? BL2 : ADV;
    assign r2 = tp  != '0 ? PR  : r3;
    assign r1 = tb1 != '0 ? BL1 : r2;
    assign r0 = ti  != '0 ? IZ  : r1;
    assign afterPhase = state == IZ ? r1 : state == BL1 ? r2 : state == PR ? r3 : ADV;

    function automatic logic [IW-1:0] phaseLen(input state_t s);
        return s == IZ ? ti : s == BL1 ? tb1 : s == PR ? tp : s == BL2 ? tb2 : '0;
    endfunction

    // next-state look-ahead so that consecutive phases follow without gap cycles
    always_comb begin
        nxt      = state;
        nxtCnt   = cnt;
        nxtIdx   = idx;
        dds      = 1'b0;
        req      = 1'b0;
        beginImp = 1'b0;
        endImp   = 1'b0;
        if (state != IDLE && ABORT)
            nxt = IDLE;
        else if (state == IDLE) begin
            if (DATA_WR) begin
                nxtIdx = '0;
                req    = N_impulse == '0;
                nxt    = N_impulse == '0 ? IDLE : ARMED;
            end
        end else if (state == ARMED)
            beginImp = TIME >= tStart;
        else if (state == ADV)
            endImp = 1'b1;
        else if (cnt == IW'(1)) begin
            endImp = afterPhase == ADV;
            nxt    = afterPhase == ADV ? state : afterPhase;
            nxtCnt = phaseLen(afterPhase);
        end else
            nxtCnt = cnt - IW'(1);
        if (endImp) begin
            req      = idx + 16'd1 == nImp;
            nxt      = req ? IDLE : nxt;
            nxtIdx   = req ? idx : idx + 16'd1;
            beginImp = !req;
        end
        if (beginImp) begin
            nxt    = r0;
            nxtCnt = phaseLen(r0);
            dds    = typ != 2'd0 || nxtIdx == '0;
        end
    end

    // state, shadow command registers and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            tStart    <= '0;
            nImp      <= '0;
            typ       <= '0;
            ti        <= '0;
            tp        <= '0;
            tb1       <= '0;
            tb2       <= '0;
            En_Iz     <= 1'b0;
            En_Pr     <= 1'b0;
            DDS_START <= 1'b0;
            BUSY      <= 1'b0;
            REQ_COMM  <= 1'b0;
            LATE      <= 1'b0;
            CMD_REJ   <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= nxtCnt;
            idx       <= nxtIdx;
            En_Iz     <= nxt == IZ;
            En_Pr     <= nxt == PR;
            DDS_START <= dds;
            BUSY      <= nxt != IDLE;
            REQ_COMM  <= req;
            LATE      <= load && TIME > TIME_START;
            CMD_REJ   <= DATA_WR && state != IDLE;
            if (load) begin
                tStart <= TIME_START;
                nImp   <= N_impulse;
                typ    <= TYPE_impulse;
                ti     <= Interval_Ti;
                tp     <= Interval_Tp;
                tb1    <= Tblank1;
                tb2    <= Tblank2;
            end
        end
    end

`ifdef PULSE_IDX_EN
    assign PULSE_IDX = idx;
`endif

endmodule

// File: tb/tb_pulse_seq_gen.sv
// tb_pulse_seq_gen: table vectors, hand sequences and random commands against a timeline model
module tb_pulse_seq_gen;

    localparam int TW = 64;
    localparam int IW = 32;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] TIME = '0;
    logic          DATA_WR = 1'b0;
    logic [TW-1:0] TIME_START = '0;
    logic [15:0]   N_impulse = '0;
    logic [1:0]    TYPE_impulse = '0;
    logic [IW-1:0] Interval_Ti = '0, Interval_Tp = '0, Tblank1 = '0, Tblank2 = '0;
    logic          ABORT = 1'b0;
    logic          En_Iz, En_Pr, DDS_START, BUSY, REQ_COMM, LATE, CMD_REJ;
`ifdef PULSE_IDX_EN
    logic [15:0]   PULSE_IDX;
`endif

    pulse_seq_gen #(.TW(TW), .IW(IW)) dut (
        .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .DATA_WR(DATA_WR), .TIME_START(TIME_START),
        .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
        .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2), .ABORT(ABORT),
        .En_Iz(En_Iz), .En_Pr(En_Pr), .DDS_START(DDS_START), .BUSY(BUSY),
        .REQ_COMM(REQ_COMM), .LATE(LATE), .CMD_REJ(CMD_REJ)
`ifdef PULSE_IDX_EN
        , .PULSE_IDX(PULSE_IDX)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] start;
        int n, typ, ti, tb1, tp, tb2;
    } cmd_t;

    typedef struct {
        longint t0, start;
        int n, typ, ti, tb1, tp, tb2;
        int late, ddsAt, ddsCnt, iz, pr, prStart, reqAt;
    } row_t;

    int vectors = 0;
    int miscompares = 0;
    // expected {En_Iz, En_Pr, DDS_START, BUSY, REQ_COMM, LATE, CMD_REJ} per cycle after load
    bit [6:0] expQ[$];
    int       idxQ[$];
    int mLate, mDdsAt, mDdsCnt, mIz, mPr, mPrStart, mReqAt, mOverlap;

    function automatic bit [6:0] obs();
        return {En_Iz, En_Pr, DDS_START, BUSY, REQ_COMM, LATE, CMD_REJ};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
        end
    endtask

    task automatic drive(input cmd_t c);
        TIME_START   = c.start;
        N_impulse    = 16'(c.n);
        TYPE_impulse = 2'(c.typ);
        Interval_Ti  = IW'(c.ti);
        Tblank1      = IW'(c.tb1);
        Interval_Tp  = IW'(c.tp);
        Tblank2      = IW'(c.tb2);
    endtask

    task automatic garbage();
        TIME_START   = {32'($urandom), 32'($urandom)};
        N_impulse    = 16'($urandom);
        TYPE_impulse = 2'($urandom);
        Interval_Ti  = $urandom;
        Tblank1      = $urandom;
        Interval_Tp  = $urandom;
        Tblank2      = $urandom;
    endtask

    task automatic setBit(input int k, input int b);
        bit [6:0] t;
        t = expQ[k];
        t[b] = 1'b1;
        expQ[k] = t;
    endtask

    // Timeline model: waits, then lays out each impulse's windows back to back
    task automatic buildExp(input cmd_t c, input logic [63:0] t0, output int L);
        int w, first;
        expQ.delete();
        idxQ.delete();
        expQ.push_back(7'b0);
        idxQ.push_back(0);
        if (c.n == 0) begin
            expQ.push_back(7'b0000100);
            idxQ.push_back(0);
            L = 1;
        end else begin
            w = (c.start > t0 + 64'd1) ? int'(c.start - t0) : 1;
            repeat (w) begin expQ.push_back(7'b0001000); idxQ.push_back(0); end
            for (int imp = 0; imp < c.n; imp++) begin
                first = expQ.size();
                if (c.ti + c.tb1 + c.tp + c.tb2 == 0) begin
                    expQ.push_back(7'b0001000);
                    idxQ.push_back(imp);
                end
                repeat (c.ti)  begin expQ.push_back(7'b1001000); idxQ.push_back(imp); end
                repeat (c.tb1) begin expQ.push_back(7'b0001000); idxQ.push_back(imp); end
                repeat (c.tp)  begin expQ.push_back(7'b0101000); idxQ.push_back(imp); end
                repeat (c.tb2) begin expQ.push_back(7'b0001000); idxQ.push_back(imp); end
                if (c.typ != 0 || imp == 0) setBit(first, 4);
            end
            L = expQ.size();
            expQ.push_back(7'b0000100);
            idxQ.push_back(c.n - 1);
        end
        if (t0 > c.start) setBit(1, 1);
        repeat (3) begin expQ.push_back(7'b0); idxQ.push_back(0); end
    endtask

    // rejAt/abortAt: 0 none, >0 that cycle, <0 random cycle while busy
    task automatic runVec(input cmd_t c, input int rejAt, input int abortAt, input string tag);
        int L;
        buildExp(c, TIME, L);
        if (rejAt < 0) rejAt = L > 1 ? int'($urandom_range(L - 1, 1)) : 0;
        if (abortAt < 0) abortAt = L > 1 ? int'($urandom_range(L - 1, 1)) : 0;
        if (rejAt > 0) setBit(rejAt + 1, 0);
        if (abortAt > 0)
            for (int k = abortAt + 1; k < expQ.size(); k++) expQ[k] = 7'b0;
        drive(c);
        DATA_WR = 1'b1;
        for (int k = 1; k < expQ.size(); k++) begin
            @(negedge CLK);
            chk($sformatf("%s c%0d", tag, k), int'(obs()), int'(expQ[k]));
`ifdef PULSE_IDX_EN
            if (expQ[k][3]) chk($sformatf("%s idx c%0d", tag, k), int'(PULSE_IDX), idxQ[k]);
`endif
            DATA_WR = k == rejAt;
            ABORT   = k == abortAt;
            garbage();
            TIME = TIME + 64'd1;
        end
        DATA_WR = 1'b0;
        ABORT   = 1'b0;
    endtask

    task automatic measure(input cmd_t c);
        mLate = 0; mDdsAt = -1; mDdsCnt = 0; mIz = 0; mPr = 0; mPrStart = -1; mReqAt = -1; mOverlap = 0;
        drive(c);
        DATA_WR = 1'b1;
        for (int k = 1; k <= 6000; k++) begin
            @(negedge CLK);
            mLate += int'(LATE);
            if (DDS_START) begin
                if (mDdsAt < 0) mDdsAt = k;
                mDdsCnt++;
            end
            mIz += int'(En_Iz);
            if (En_Pr) begin
                if (mPrStart < 0) mPrStart = k;
                mPr++;
            end
            mOverlap += int'(En_Iz && En_Pr);
            if (REQ_COMM && mReqAt < 0) mReqAt = k;
            DATA_WR = 1'b0;
            garbage();
            TIME = TIME + 64'd1;
            if (mReqAt >= 0 && k >= mReqAt + 2) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        row_t tbl[9];
        cmd_t c;
        string nm;
        //           t0    start n typ  ti tb1 tp tb2 | late ddsAt cnt iz  pr  prSt  reqAt
        tbl[0] = '{0,    4800, 1, 0, 100, 10, 50, 5,   0, 4801, 1, 100, 50, 4911, 4966};
        tbl[1] = '{1000, 1005, 3, 1, 20,  0,  20, 0,   0, 6,    3, 60,  60, 26,   126};
        tbl[2] = '{500,  10,   1, 0, 3,   2,  2,  2,   1, 2,    1, 3,   2,  7,    11};
        tbl[3] = '{2000, 2003, 0, 1, 5,   5,  5,  5,   0, -1,   0, 0,   0,  -1,   1};
        tbl[4] = '{3000, 3002, 3, 1, 0,   0,  0,  0,   0, 3,    3, 0,   0,  -1,   6};
        tbl[5] = '{4000, 4001, 2, 0, 0,   2,  3,  1,   0, 2,    1, 0,   6,  4,    14};
        tbl[6] = '{5000, 5001, 1, 0, 1,   0,  1,  0,   0, 2,    1, 1,   1,  3,    4};
        tbl[7] = '{6000, 6000, 1, 0, 1,   0,  1,  0,   0, 2,    1, 1,   1,  3,    4};
        tbl[8] = '{7000, 7001, 2, 2, 1,   0,  0,  1,   0, 2,    2, 2,   0,  -1,   6};

        repeat (3) @(negedge CLK);
        chk("reset outputs", int'(obs()), 0);
`ifdef PULSE_IDX_EN
        chk("reset idx", int'(PULSE_IDX), 0);
`endif
        rst_n = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            TIME = 64'(tbl[i].t0);
            c = '{64'(tbl[i].start), tbl[i].n, tbl[i].typ, tbl[i].ti, tbl[i].tb1, tbl[i].tp, tbl[i].tb2};
            measure(c);
            nm = $sformatf("row%0d", i);
            chk({nm, " late"},    mLate,    tbl[i].late);
            chk({nm, " ddsAt"},   mDdsAt,   tbl[i].ddsAt);
            chk({nm, " ddsCnt"},  mDdsCnt,  tbl[i].ddsCnt);
            chk({nm, " izCyc"},   mIz,      tbl[i].iz);
            chk({nm, " prCyc"},   mPr,      tbl[i].pr);
            chk({nm, " prStart"}, mPrStart, tbl[i].prStart);
            chk({nm, " reqAt"},   mReqAt,   tbl[i].reqAt);
            chk({nm, " overlap"}, mOverlap, 0);
        end

        TIME = 64'd10000;
        runVec('{TIME + 64'd1, 2, 0, 3, 1, 6, 1}, 8, 0, "rej in PR");
        runVec('{TIME + 64'd1, 1, 0, 2, 1, 2, 1}, 7, 0, "rej at done");
        runVec('{TIME + 64'd1, 1, 0, 100, 5, 5, 5}, 0, 32, "abort in IZ");
        runVec('{TIME + 64'd3, 1, 1, 4, 2, 4, 2}, 0, 0, "after abort");
        runVec('{TIME + 64'd2, 4, 1, 2, 1, 2, 1}, 0, 0, "four pulses");

        c = '{TIME + 64'd1, 1, 0, 2, 0, 10, 0};
        drive(c);
        DATA_WR = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            DATA_WR = 1'b0;
            garbage();
            TIME = TIME + 64'd1;
        end
        chk("PR before reset", int'(En_Pr), 1);
        #2 rst_n = 1'b0;
        #1 chk("async reset outputs", int'(obs()), 0);
`ifdef PULSE_IDX_EN
        chk("async reset idx", int'(PULSE_IDX), 0);
`endif
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        chk("post reset idle", int'(obs()), 0);

        for (int r = 0; r < 30; r++) begin
            int mode;
            c.start = TIME + 64'($urandom_range(12, 0)) - 64'd4;
            c.n   = int'($urandom_range(4, 0));
            c.typ = int'($urandom_range(3, 0));
            c.ti  = int'($urandom_range(5, 0));
            c.tb1 = int'($urandom_range(3, 0));
            c.tp  = int'($urandom_range(5, 0));
            c.tb2 = int'($urandom_range(3, 0));
            mode = int'($urandom_range(2, 0));
            runVec(c, mode == 1 ? -1 : 0, mode == 2 ? -1 : 0, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_seq_gen.md
Name: pulse_seq_gen

Overview:
- Pulse timing sequencer downstream of wcm, in parallel with master_start's DDS handshake path.
- Takes one command from the wcm memory outputs (DATA_WR strobe plus the *_z fields).
- Waits until the system time reaches TIME_START, then runs N transmit/receive cycles.
- Drives En_Iz (transmit window), En_Pr (receive window) and a one-cycle DDS_START per transmit window, then requests the next command.

Parameters:
- TW, 64, system-time width (TIME, TIME_START).
- IW, 32, width of interval/blank counters.

Ports:
- CLK  in  1  system clock (48 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- TIME  in  TW  running system time, +1 per CLK when counting.
- DATA_WR  in  1  one-cycle command load strobe.
- TIME_START  in  TW  start time of the command.
- N_impulse  in  16  number of Iz/Pr cycles.
- TYPE_impulse  in  2  0 = single DDS_START per command, 1 = DDS_START per impulse; 2 and 3 behave as 1.
- Interval_Ti  in  IW  transmit window length, CLK cycles.
- Interval_Tp  in  IW  receive window length, CLK cycles.
- Tblank1  in  IW  blank between Iz and Pr, CLK cycles.
- Tblank2  in  IW  blank after Pr, CLK cycles.
- ABORT  in  1  synchronous cancel.
- En_Iz  out  1  transmit enable.
- En_Pr  out  1  receive enable.
- DDS_START  out  1  one-cycle chirp start strobe.
- BUSY  out  1  command held (ARMED or running).
- REQ_COMM  out  1  one-cycle request for the next command.
- LATE  out  1  one-cycle flag: start time already past at load.
- CMD_REJ  out  1  one-cycle flag: DATA_WR ignored because busy.

Behaviour:
- Reset state: all outputs 0, FSM IDLE, all registers cleared.
- Reset asserted mid-sequence drops En_Iz and En_Pr in the same cycle, asynchronously.
- DATA_WR in IDLE:
  - Latches all fields into shadow registers.
  - Next state ARMED, BUSY=1.
  - LATE=1 on the following cycle if TIME > TIME_START at the load cycle.
- DATA_WR while BUSY: fields are not latched; CMD_REJ pulses on the next cycle.
- ARMED → IZ when TIME >= latched TIME_START, compared every cycle. A late start therefore begins on the next cycle.
- N_impulse = 0 at load: no ARMED state; REQ_COMM pulses one cycle after load; BUSY stays 0.
- Phase order per impulse: IZ (Ti) → BL1 (Tblank1) → PR (Tp) → BL2 (Tblank2).
- Phase timing:
  - Each phase lasts exactly its value in CLK cycles.
  - A phase with value 0 is skipped with zero cycles spent.
  - A single down-counter is reloaded at each phase entry.
  - Transitions are combinational look-ahead, so consecutive phases have no gap cycles.
- Outputs by state: En_Iz=1 exactly in IZ; En_Pr=1 exactly in PR; both registered, never high together.
- DDS_START:
  - Asserted in the first IZ cycle.
  - TYPE_impulse=0: only on impulse 0.
  - Otherwise: on every impulse.
  - If Ti=0, DDS_START still pulses at what would have been the IZ entry cycle.
- Impulse counter:
  - 16-bit, increments at BL2 exit.
  - When it equals N_impulse: go to IDLE, BUSY=0, REQ_COMM pulses in the same cycle IDLE is entered.
- All phases zero: each impulse takes 1 cycle (the counter-advance cycle), preventing a zero-time loop.
- ABORT:
  - In any non-IDLE state: next cycle is IDLE, En_* = 0, BUSY=0.
  - No REQ_COMM.
  - ABORT has priority over a simultaneous DATA_WR.
- Simultaneous DATA_WR and sequence completion in the same cycle: the command is rejected (CMD_REJ).
- Counter rule: a value of 2^IW−1 is a valid length; there is no wrap-around and no saturation.

Optional Feature:
- Macro PULSE_IDX_EN.
- Defined: adds output PULSE_IDX[15:0] with the current impulse index (0-based). It is valid while BUSY, holds its last value in IDLE, and resets to 0.
- Undefined: no port, no extra logic; all other behaviour is identical.

Test Plan:
- Load TIME_START=4800, TIME=0, N=1, Ti=100, Tb1=10, Tp=50, Tb2=5, TYPE=0 → DDS_START at TIME=4800; En_Iz high 100 cycles; En_Pr high 50 cycles starting 10 cycles after En_Iz falls; REQ_COMM 5 cycles after En_Pr falls; BUSY low.
- N=3, TYPE=1, Ti=20, Tb1=0, Tp=20, Tb2=0 → 3 DDS_START pulses spaced 40 cycles apart; no gap between En_Iz fall and En_Pr rise.
- Load with TIME_START=10 while TIME=500 → LATE pulse; sequence starts on the next cycle.
- Second DATA_WR during PR → CMD_REJ pulse; first sequence completes unaltered.
- ABORT 30 cycles into IZ (Ti=100) → En_Iz low the next cycle; BUSY 0; no REQ_COMM; fresh load then runs normally.
- rst_n low during PR → En_Pr drops immediately; all outputs 0. With PULSE_IDX_EN, N=4 shows PULSE_IDX stepping 0,1,2,3.
